// File: rtl/aes_engine.sv
// AES command engine: SET_KEY / ENCRYPT / DECRYPT over valid/ready, iterative one-round-per-cycle
// cipher and inverse cipher, round keys expanded into and read back from a small key SRAM.
package aes_pkg;
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // GF(2^8) inverse as a^254 by an addition chain; maps 0 to 0 as the S-box needs.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] a2, a3, a6, a12, a15, a240;
      a2   = gmul(a, a);
      a3   = gmul(a2, a);
      a6   = gmul(a3, a3);
      a12  = gmul(a6, a6);
      a15  = gmul(a12, a3);
      a240 = a15;
      for (int k = 0; k < 4; k++) a240 = gmul(a240, a240);
      return gmul(gmul(a240, a12), a2);
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Byte k of the block is bits [127-8k -: 8]; column c holds bytes 4c..4c+3.
   function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [0:15][7:0] sv, b, t;
      sv = s;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            b[4*c+r] = sbox(sv[4*((c+r)%4)+r]);
      t = b;
      if (!last)
         for (int c = 0; c < 4; c++) begin
            t[4*c]   = xtime(b[4*c]) ^ xtime(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
            t[4*c+1] = b[4*c] ^ xtime(b[4*c+1]) ^ xtime(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
            t[4*c+2] = b[4*c] ^ b[4*c+1] ^ xtime(b[4*c+2]) ^ xtime(b[4*c+3]) ^ b[4*c+3];
            t[4*c+3] = xtime(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xtime(b[4*c+3]);
         end
      return t ^ rk;
   endfunction

   function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [0:15][7:0] sv, b, t;
      sv = s;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            b[4*c+r] = inv_sbox(sv[4*((c+4-r)%4)+r]);
      b = b ^ rk;
      t = b;
      if (!last)
         for (int c = 0; c < 4; c++) begin
            t[4*c]   = gmul(b[4*c], 8'h0e) ^ gmul(b[4*c+1], 8'h0b) ^ gmul(b[4*c+2], 8'h0d) ^ gmul(b[4*c+3], 8'h09);
            t[4*c+1] = gmul(b[4*c], 8'h09) ^ gmul(b[4*c+1], 8'h0e) ^ gmul(b[4*c+2], 8'h0b) ^ gmul(b[4*c+3], 8'h0d);
            t[4*c+2] = gmul(b[4*c], 8'h0d) ^ gmul(b[4*c+1], 8'h09) ^ gmul(b[4*c+2], 8'h0e) ^ gmul(b[4*c+3], 8'h0b);
            t[4*c+3] = gmul(b[4*c], 8'h0b) ^ gmul(b[4*c+1], 8'h0d) ^ gmul(b[4*c+2], 8'h09) ^ gmul(b[4*c+3], 8'h0e);
         end
      return t;
   endfunction
endpackage

module aes_key_sram (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         we_i,
   input  logic         re_i,
   input  logic [3:0]   addr_i,
   input  logic [127:0] wdata_i,
   output logic [127:0] rdata_o
);
   logic [127:0] mem_q [16];
   logic [127:0] rdata_q;

   always_ff @(posedge clk)
      if (we_i) mem_q[addr_i] <= wdata_i;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)    rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[addr_i];

   assign rdata_o = rdata_q;
endmodule

// One schedule word per cycle; every fourth word completes a round key and is written out.
module aes_key_exp #(parameter int NK = 4, parameter int NR = 10) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic [255:0] key_i,
   output logic         we_o,
   output logic [3:0]   addr_o,
   output logic [127:0] wdata_o,
   output logic         done_o
);
   import aes_pkg::*;
   localparam int NW = 4 * (NR + 1);

   logic             busy_q, we_q, done_q;
   logic [5:0]       i_q;
   logic [2:0]       kc_q;
   logic [7:0]       rcon_q;
   logic [0:7][31:0] win_q;
   logic [95:0]      acc_q;
   logic [3:0]       addr_q;
   logic [127:0]     wdata_q;
   logic [31:0]      tmp, word;

   // win_q[0] is w[i-NK], win_q[NK-1] is w[i-1]; the first NK words are the key itself.
   always_comb begin
      tmp = win_q[NK-1];
      if (kc_q == 3'd0)              tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon_q, 24'h0};
      else if (NK > 6 && kc_q == 3'd4) tmp = sub_word(tmp);
      word = (i_q < 6'(NK)) ? win_q[i_q[2:0]] : (win_q[0] ^ tmp);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         i_q     <= '0;
         kc_q    <= '0;
         rcon_q  <= 8'h01;
         win_q   <= '0;
         acc_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         if (start_i) begin
            busy_q <= 1'b1;
            i_q    <= '0;
            kc_q   <= '0;
            rcon_q <= 8'h01;
            win_q  <= key_i;
         end else if (busy_q) begin
            i_q   <= i_q + 6'd1;
            kc_q  <= (kc_q == 3'(NK-1)) ? 3'd0 : kc_q + 3'd1;
            acc_q <= {acc_q[63:0], word};
            if (i_q >= 6'(NK)) begin
               for (int j = 0; j < 7; j++)
                  if (j < NK - 1) win_q[j] <= win_q[j+1];
               win_q[NK-1] <= word;
               if (kc_q == 3'd0) rcon_q <= xtime(rcon_q);
            end
            if (i_q[1:0] == 2'd3) begin
               we_q    <= 1'b1;
               addr_q  <= i_q[5:2];
               wdata_q <= {acc_q, word};
            end
            if (i_q == 6'(NW-1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign we_o    = we_q;
   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;
   assign done_o  = done_q;
endmodule

// Round r consumes the key read in the previous cycle and prefetches the key for r+1.
module aes_cipher #(parameter int NR = 10, parameter bit INV = 1'b0) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic [127:0] blk_i,
   input  logic [127:0] rk_i,
   output logic         rd_en_o,
   output logic [3:0]   addr_o,
   output logic         done_o,
   output logic [127:0] res_o
);
   import aes_pkg::*;
   localparam logic [3:0] NRL = 4'(NR);

   logic         busy_q, done_q;
   logic [3:0]   rnd_q, nxt;
   logic [127:0] st_q;

   always_comb begin
      nxt     = start_i ? 4'd0 : rnd_q + 4'd1;
      rd_en_o = start_i | (busy_q && rnd_q != NRL);
      addr_o  = INV ? NRL - nxt : nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         rnd_q  <= '0;
         st_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            busy_q <= 1'b1;
            rnd_q  <= '0;
            st_q   <= blk_i;
         end else if (busy_q) begin
            rnd_q <= rnd_q + 4'd1;
            if (rnd_q == 4'd0) st_q <= st_q ^ rk_i;
            else if (INV)      st_q <= dec_round(st_q, rk_i, rnd_q == NRL);
            else               st_q <= enc_round(st_q, rk_i, rnd_q == NRL);
            if (rnd_q == NRL) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done_o = done_q;
   assign res_o  = st_q;
endmodule

module aes_engine #(
   parameter int KEY_S          = 128,
   parameter int ENABLE_DECRYPT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      aes_cmd,
   input  logic [KEY_S-1:0] aes_key,
   input  logic [127:0]     aes_block,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     aes_result,
   output logic [1:0]       out_status,
   output logic             key_loaded
);
   localparam int NK = KEY_S / 32;
   localparam int NR = NK + 6;
   localparam logic [31:0] CMD_SET_KEY = 32'h1;
   localparam logic [31:0] CMD_ENCRYPT = 32'h2;
   localparam logic [31:0] CMD_DECRYPT = 32'h3;
   localparam logic [1:0]  ST_OK = 2'd0, ST_NO_KEY = 2'd1, ST_BAD_CMD = 2'd2;

   if (KEY_S != 128 && KEY_S != 192 && KEY_S != 256) begin : g_bad_key_s
      $error("aes_engine: KEY_S must be 128, 192 or 256");
   end

   typedef enum logic [2:0] {IDLE, KEYEXP, ENC, DEC, RESP} state_e;

   state_e       state_q;
   logic         in_ready_q, out_valid_q, key_loaded_q;
   logic         ke_start_q, enc_start_q, dec_start_q;
   logic [255:0] key_q;
   logic [127:0] blk_q, result_q;
   logic [1:0]   status_q;

   logic         ke_we, ke_done, enc_re, enc_done, dec_re, dec_done;
   logic [3:0]   ke_addr, enc_addr, dec_addr;
   logic [127:0] ke_wdata, enc_res, dec_res;
   logic         sram_we, sram_re;
   logic [3:0]   sram_addr;
   logic [127:0] sram_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         key_loaded_q <= 1'b0;
         ke_start_q   <= 1'b0;
         enc_start_q  <= 1'b0;
         dec_start_q  <= 1'b0;
         key_q        <= '0;
         blk_q        <= '0;
         result_q     <= '0;
         status_q     <= ST_OK;
      end else begin
         ke_start_q  <= 1'b0;
         enc_start_q <= 1'b0;
         dec_start_q <= 1'b0;
         case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
               in_ready_q <= 1'b0;
               result_q   <= '0;
               status_q   <= ST_OK;
               case (aes_cmd)
                  CMD_SET_KEY: begin
                     key_q        <= 256'(aes_key) << (256 - KEY_S);
                     key_loaded_q <= 1'b0;
                     ke_start_q   <= 1'b1;
                     state_q      <= KEYEXP;
                  end
                  CMD_ENCRYPT: begin
                     blk_q <= aes_block;
                     if (key_loaded_q) begin
                        enc_start_q <= 1'b1;
                        state_q     <= ENC;
                     end else begin
                        status_q    <= ST_NO_KEY;
                        out_valid_q <= 1'b1;
                        state_q     <= RESP;
                     end
                  end
                  CMD_DECRYPT: begin
                     blk_q <= aes_block;
                     if (ENABLE_DECRYPT == 0) begin
                        status_q    <= ST_BAD_CMD;
                        out_valid_q <= 1'b1;
                        state_q     <= RESP;
                     end else if (!key_loaded_q) begin
                        status_q    <= ST_NO_KEY;
                        out_valid_q <= 1'b1;
                        state_q     <= RESP;
                     end else begin
                        dec_start_q <= 1'b1;
                        state_q     <= DEC;
                     end
                  end
                  default: begin
                     status_q    <= ST_BAD_CMD;
                     out_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end
               endcase
            end
            KEYEXP: if (ke_done) begin
               key_loaded_q <= 1'b1;
               out_valid_q  <= 1'b1;
               state_q      <= RESP;
            end
            ENC: if (enc_done) begin
               result_q    <= enc_res;
               out_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            DEC: if (dec_done) begin
               result_q    <= dec_res;
               out_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The SRAM port belongs to whichever submodule the current state is running.
   always_comb begin
      sram_we    = 1'b0;
      sram_re    = 1'b0;
      sram_addr  = '0;
      case (state_q)
         KEYEXP: begin sram_we = ke_we;  sram_addr = ke_addr;  end
         ENC:    begin sram_re = enc_re; sram_addr = enc_addr; end
         DEC:    begin sram_re = dec_re; sram_addr = dec_addr; end
         default: ;
      endcase
   end

   aes_key_sram u_sram (
      .clk(clk), .rst_n(reset), .we_i(sram_we), .re_i(sram_re),
      .addr_i(sram_addr), .wdata_i(ke_wdata), .rdata_o(sram_rdata)
   );

   aes_key_exp #(.NK(NK), .NR(NR)) u_key_exp (
      .clk(clk), .rst_n(reset), .start_i(ke_start_q), .key_i(key_q),
      .we_o(ke_we), .addr_o(ke_addr), .wdata_o(ke_wdata), .done_o(ke_done)
   );

   aes_cipher #(.NR(NR), .INV(1'b0)) u_enc (
      .clk(clk), .rst_n(reset), .start_i(enc_start_q), .blk_i(blk_q), .rk_i(sram_rdata),
      .rd_en_o(enc_re), .addr_o(enc_addr), .done_o(enc_done), .res_o(enc_res)
   );

   if (ENABLE_DECRYPT != 0) begin : g_dec
      aes_cipher #(.NR(NR), .INV(1'b1)) u_dec (
         .clk(clk), .rst_n(reset), .start_i(dec_start_q), .blk_i(blk_q), .rk_i(sram_rdata),
         .rd_en_o(dec_re), .addr_o(dec_addr), .done_o(dec_done), .res_o(dec_res)
      );
   end else begin : g_no_dec
      assign dec_re   = 1'b0;
      assign dec_addr = '0;
      assign dec_done = 1'b0;
      assign dec_res  = '0;
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign aes_result = result_q;
   assign out_status = status_q;
   assign key_loaded = key_loaded_q;
endmodule

// File: tb/tb_aes_engine.sv
// Bench for aes_engine: four instances (128/192/256-bit keys, and 128-bit without decrypt)
// driven one at a time, responses compared against a queue of expected results.
module tb_aes_engine;
   localparam logic [31:0]  SET_KEY = 32'h1, ENCRYPT = 32'h2, DECRYPT = 32'h3;
   localparam logic [1:0]   OK = 2'd0, NO_KEY = 2'd1, BAD_CMD = 2'd2;
   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   typedef struct packed {
      logic [1:0]   st;
      logic [127:0] res;
   } resp_t;

   resp_t exp_q[$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0]   in_valid = '0;
   logic [31:0]  aes_cmd = '0;
   logic [127:0] aes_block = '0;
   logic         out_ready = 1'b0;
   logic [255:0] key_w = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   logic [3:0]   in_ready, out_valid, key_loaded;
   logic [3:0][127:0] res;
   logic [3:0][1:0]   st;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_engine #(.KEY_S(128), .ENABLE_DECRYPT(1)) u_d0 (
      .clk(clk), .reset(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .aes_cmd(aes_cmd),
      .aes_key(key_w[255:128]), .aes_block(aes_block), .out_valid(out_valid[0]), .out_ready(out_ready),
      .aes_result(res[0]), .out_status(st[0]), .key_loaded(key_loaded[0]));
   aes_engine #(.KEY_S(192), .ENABLE_DECRYPT(1)) u_d1 (
      .clk(clk), .reset(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .aes_cmd(aes_cmd),
      .aes_key(key_w[255:64]), .aes_block(aes_block), .out_valid(out_valid[1]), .out_ready(out_ready),
      .aes_result(res[1]), .out_status(st[1]), .key_loaded(key_loaded[1]));
   aes_engine #(.KEY_S(256), .ENABLE_DECRYPT(1)) u_d2 (
      .clk(clk), .reset(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .aes_cmd(aes_cmd),
      .aes_key(key_w), .aes_block(aes_block), .out_valid(out_valid[2]), .out_ready(out_ready),
      .aes_result(res[2]), .out_status(st[2]), .key_loaded(key_loaded[2]));
   aes_engine #(.KEY_S(128), .ENABLE_DECRYPT(0)) u_d3 (
      .clk(clk), .reset(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .aes_cmd(aes_cmd),
      .aes_key(key_w[255:128]), .aes_block(aes_block), .out_valid(out_valid[3]), .out_ready(out_ready),
      .aes_result(res[3]), .out_status(st[3]), .key_loaded(key_loaded[3]));

   // Drive one command into instance d and wait (bounded) for its response; lat counts cycles after accept.
   task automatic issue(input int d, input logic [31:0] cmd, input logic [127:0] blk,
                        output resp_t obs, output int lat);
      int n;
      @(negedge clk);
      aes_cmd = cmd;
      aes_block = blk;
      in_valid = '0;
      in_valid[d] = 1'b1;
      n = 0;
      while (in_ready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      in_valid = '0;
      lat = 1;
      while (out_valid[d] !== 1'b1 && lat < 300) begin @(negedge clk); lat++; end
      if (out_valid[d] === 1'b1) begin
         obs.st  = st[d];
         obs.res = res[d];
      end else obs = 'x;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 4'hf || out_valid !== 4'h0 || key_loaded !== 4'h0) begin
         errors++;
         $display("FAIL reset_flags: in_ready=%b out_valid=%b key_loaded=%b want 1111 0000 0000",
                  in_ready, out_valid, key_loaded);
      end
      checks++;
      if (res[0] !== '0 || st[0] !== OK) begin
         errors++;
         $display("FAIL reset_outputs: result=%h status=%0d want 0 0", res[0], st[0]);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_no_key();
      resp_t obs, e;
      int lat;
      exp_q.push_back('{NO_KEY, 128'h0});
      issue(0, ENCRYPT, PT, obs, lat);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL no_key_resp: got st=%0d res=%h want st=%0d res=%h", obs.st, obs.res, e.st, e.res);
      end
      checks++;
      if (lat !== 1 || key_loaded[0] !== 1'b0) begin
         errors++;
         $display("FAIL no_key_timing: latency=%0d key_loaded=%b want 1 0", lat, key_loaded[0]);
      end
      consume();
   endtask

   task automatic test_key_size(input int d, input logic [127:0] ct, input string nm);
      resp_t obs, e;
      int lat;
      exp_q.push_back('{OK, 128'h0});
      issue(d, SET_KEY, '0, obs, lat);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e || key_loaded[d] !== 1'b1) begin
         errors++;
         $display("FAIL %s_set_key: got st=%0d res=%h kl=%b want st=%0d res=%h kl=1",
                  nm, obs.st, obs.res, key_loaded[d], e.st, e.res);
      end
      consume();
      exp_q.push_back('{OK, ct});
      issue(d, ENCRYPT, PT, obs, lat);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL %s_encrypt: got st=%0d res=%h want st=%0d res=%h", nm, obs.st, obs.res, e.st, e.res);
      end
      consume();
      exp_q.push_back('{OK, PT});
      issue(d, DECRYPT, ct, obs, lat);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL %s_decrypt: got st=%0d res=%h want st=%0d res=%h", nm, obs.st, obs.res, e.st, e.res);
      end
      consume();
   endtask

   // A SET_KEY held on the input during a stalled response must not be accepted nor disturb it.
   task automatic test_backpressure();
      resp_t obs, e;
      int lat;
      exp_q.push_back('{OK, CT128});
      issue(0, ENCRYPT, PT, obs, lat);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL bp_resp: got st=%0d res=%h want st=%0d res=%h", obs.st, obs.res, e.st, e.res);
      end
      aes_cmd = SET_KEY;
      in_valid[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || res[0] !== e.res || st[0] !== e.st) begin
            errors++;
            $display("FAIL bp_hold[%0d]: ov=%b ir=%b st=%0d res=%h want ov=1 ir=0 st=%0d res=%h",
                     i, out_valid[0], in_ready[0], st[0], res[0], e.st, e.res);
         end
      end
      in_valid = '0;
      consume();
      checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || key_loaded[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: ir=%b ov=%b kl=%b want 1 0 1", in_ready[0], out_valid[0], key_loaded[0]);
      end
   endtask

   task automatic test_bad_cmd();
      resp_t obs, e;
      int lat;
      exp_q.push_back('{BAD_CMD, 128'h0});
      issue(0, 32'hdeadbeef, PT, obs, lat);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e || lat !== 1 || key_loaded[0] !== 1'b1) begin
         errors++;
         $display("FAIL bad_code: got st=%0d res=%h lat=%0d kl=%b want st=%0d res=%h lat=1 kl=1",
                  obs.st, obs.res, lat, key_loaded[0], e.st, e.res);
      end
      consume();
      exp_q.push_back('{OK, 128'h0});
      issue(3, SET_KEY, '0, obs, lat);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e || key_loaded[3] !== 1'b1) begin
         errors++;
         $display("FAIL nodec_set_key: got st=%0d kl=%b want st=%0d kl=1", obs.st, key_loaded[3], e.st);
      end
      consume();
      exp_q.push_back('{BAD_CMD, 128'h0});
      issue(3, DECRYPT, CT128, obs, lat);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e || lat !== 1 || key_loaded[3] !== 1'b1) begin
         errors++;
         $display("FAIL nodec_decrypt: got st=%0d res=%h lat=%0d kl=%b want st=%0d res=%h lat=1 kl=1",
                  obs.st, obs.res, lat, key_loaded[3], e.st, e.res);
      end
      consume();
   endtask

   task automatic test_reset_mid_enc();
      resp_t obs, e;
      int lat, n, seen;
      @(negedge clk);
      aes_cmd = ENCRYPT;
      aes_block = PT;
      in_valid[0] = 1'b1;
      n = 0;
      while (in_ready[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      in_valid = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || key_loaded[0] !== 1'b0 ||
          res[0] !== '0 || st[0] !== OK) begin
         errors++;
         $display("FAIL mid_reset: ov=%b ir=%b kl=%b st=%0d res=%h want 0 1 0 0 0",
                  out_valid[0], in_ready[0], key_loaded[0], st[0], res[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid[0] === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL mid_reset_no_resp: out_valid seen %0d cycles want 0", seen);
      end
      exp_q.push_back('{NO_KEY, 128'h0});
      issue(0, ENCRYPT, PT, obs, lat);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL mid_reset_no_key: got st=%0d res=%h want st=%0d res=%h", obs.st, obs.res, e.st, e.res);
      end
      consume();
   endtask

   initial begin
      test_reset();
      test_no_key();
      test_key_size(0, CT128, "k128");
      test_key_size(1, CT192, "k192");
      test_key_size(2, CT256, "k256");
      test_backpressure();
      test_bad_cmd();
      test_reset_mid_enc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
